e_mdu: RTL and testbench

- Execute-stage multiply/divide unit and sequencer for the five-stage MIPS pipeline. It sits beside E_ALU.
- Accepts mult/multu/div/divu/mfhi/mflo/mthi/mtlo from the E-stage operands and owns the HI/LO registers.
- Models multi-cycle occupancy with a down-counter and exports busy/stall information so the hazard unit can hold MDU-dependent instructions in D.

---
 rtl/e_mdu.sv | 200 ++++++++++++++++++++
 tb/tb_e_mdu.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit owning the HI/LO registers.
// Latency: mult/multu commit MULT_CYCLES and div/divu commit DIV_CYCLES cycles after the start edge; mthi/mtlo take effect at the start edge.
// Backpressure: busy/mdu_stall let the hazard unit hold MDU-dependent instructions; any start while busy is ignored.
module e_mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic [3:0]  mdu_op,
   input  logic        start,
   output logic        busy,
   output logic        mdu_stall,
   output logic [31:0] mdu_out,
   output logic [31:0] hi_q,
   output logic [31:0] lo_q
);

   // Counter is wide enough for the longer of the two occupancy times.
   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO  = '0;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [31:0]   pend_hi_q;
   logic [31:0]   pend_lo_q;
   logic          nowrite_q;
   logic          busy_q;

   // Arithmetic results computed from the E-stage operands at the start edge.
   logic [63:0] a_sx_d;
   logic [63:0] b_sx_d;
   logic [63:0] prod_s_d;
   logic [63:0] prod_u_d;
   logic        a_neg_d;
   logic        b_neg_d;
   logic [31:0] a_mag_d;
   logic [31:0] b_mag_d;
   logic        div_zero_d;
   logic [31:0] bs_safe_d;
   logic [31:0] bu_safe_d;
   logic [31:0] qs_mag_d;
   logic [31:0] rs_mag_d;
   logic [31:0] quo_s_d;
   logic [31:0] rem_s_d;
   logic [31:0] quo_u_d;
   logic [31:0] rem_u_d;

   // Full 64-bit products plus signed/unsigned quotient and remainder.
   always_comb begin
      // The low 64 bits of a 64x64 product equal the full 32x32 product,
      // so sign- or zero-extending the operands selects signed or unsigned.
      a_sx_d   = {{32{src_a[31]}}, src_a};
      b_sx_d   = {{32{src_b[31]}}, src_b};
      prod_s_d = a_sx_d * b_sx_d;
      prod_u_d = {32'd0, src_a} * {32'd0, src_b};

      // Signed divide on magnitudes: keeps 0x80000000 / -1 well defined
      // (magnitude 0x80000000, negated back to itself -> wraps, no trap).
      a_neg_d    = src_a[31];
      b_neg_d    = src_b[31];
      a_mag_d    = a_neg_d ? (~src_a + 32'd1) : src_a;
      b_mag_d    = b_neg_d ? (~src_b + 32'd1) : src_b;
      div_zero_d = (src_b == 32'd0);

      // Divisor forced to 1 on divide-by-zero; the result is discarded anyway.
      bs_safe_d = div_zero_d ? 32'd1 : b_mag_d;
      bu_safe_d = div_zero_d ? 32'd1 : src_b;

      qs_mag_d = a_mag_d / bs_safe_d;
      rs_mag_d = a_mag_d % bs_safe_d;

      // Quotient truncates toward zero; remainder follows the dividend sign.
      quo_s_d = (a_neg_d ^ b_neg_d) ? (~qs_mag_d + 32'd1) : qs_mag_d;
      rem_s_d = a_neg_d ? (~rs_mag_d + 32'd1) : rs_mag_d;

      quo_u_d = src_a / bu_safe_d;
      rem_u_d = src_a % bu_safe_d;
   end

   // Sequencer: accepts ops in IDLE, counts down occupancy in RUN, commits HI/LO on the last busy cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= CNT_ZERO;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
         nowrite_q <= 1'b0;
         busy_q    <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  case (mdu_op)
                     OP_MULT: begin
                        pend_hi_q <= prod_s_d[63:32];
                        pend_lo_q <= prod_s_d[31:0];
                        nowrite_q <= 1'b0;
                        cnt_q     <= MULT_LOAD;
                        busy_q    <= 1'b1;
                        state_q   <= S_RUN;
                     end
                     OP_MULTU: begin
                        pend_hi_q <= prod_u_d[63:32];
                        pend_lo_q <= prod_u_d[31:0];
                        nowrite_q <= 1'b0;
                        cnt_q     <= MULT_LOAD;
                        busy_q    <= 1'b1;
                        state_q   <= S_RUN;
                     end
                     OP_DIV: begin
                        pend_hi_q <= rem_s_d;
                        pend_lo_q <= quo_s_d;
                        nowrite_q <= div_zero_d;
                        cnt_q     <= DIV_LOAD;
                        busy_q    <= 1'b1;
                        state_q   <= S_RUN;
                     end
                     OP_DIVU: begin
                        pend_hi_q <= rem_u_d;
                        pend_lo_q <= quo_u_d;
                        nowrite_q <= div_zero_d;
                        cnt_q     <= DIV_LOAD;
                        busy_q    <= 1'b1;
                        state_q   <= S_RUN;
                     end
                     OP_MTHI: hi_q <= src_a;
                     OP_MTLO: lo_q <= src_a;
                     default: ;
                  endcase
               end
            end
            S_RUN: begin
               // Starts arriving here violate the stall protocol and are dropped.
               if (cnt_q == CNT_ONE) begin
                  if (!nowrite_q) begin
                     hi_q <= pend_hi_q;
                     lo_q <= pend_lo_q;
                  end
                  nowrite_q <= 1'b0;
                  cnt_q     <= CNT_ZERO;
                  busy_q    <= 1'b0;
                  state_q   <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            default: begin
               state_q <= S_IDLE;
               cnt_q   <= CNT_ZERO;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;

   // Stall covers the issuing cycle of a multi-cycle op as well as its busy window.
   always_comb begin
      mdu_stall = busy_q;
      if (start && ((mdu_op == OP_MULT) || (mdu_op == OP_MULTU) ||
                    (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU))) begin
         mdu_stall = 1'b1;
      end
   end

   // Read port returns committed HI/LO only.
   always_comb begin
      case (mdu_op)
         OP_MFHI: mdu_out = hi_q;
         OP_MFLO: mdu_out = lo_q;
         default: mdu_out = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: self-checking bench for e_mdu.
// Directed scenarios plus randomized ops compared against an arithmetic model.
// Inputs driven 1ns after the rising edge; outputs sampled there too.
module tb_e_mdu;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk;
   logic        reset;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic [3:0]  mdu_op;
   logic        start;
   logic        busy;
   logic        mdu_stall;
   logic [31:0] mdu_out;
   logic [31:0] hi_q;
   logic [31:0] lo_q;

   int n_tests;
   int n_fail;

   // Reference HI/LO state
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk       (clk),
      .reset     (reset),
      .src_a     (src_a),
      .src_b     (src_b),
      .mdu_op    (mdu_op),
      .start     (start),
      .busy      (busy),
      .mdu_stall (mdu_stall),
      .mdu_out   (mdu_out),
      .hi_q      (hi_q),
      .lo_q      (lo_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      start  = 1'b1;
      mdu_op = op;
      src_a  = a;
      src_b  = b;
   endtask

   task automatic idle_inputs();
      start  = 1'b0;
      mdu_op = 4'd0;
   endtask

   // Architectural effect of one op on the reference HI/LO; returns busy length.
   task automatic model_exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             output int cycles);
      longint      la;
      longint      lb;
      longint      lq;
      longint      lr;
      logic [63:0] p;
      cycles = 0;
      la = longint'($signed(a));
      lb = longint'($signed(b));
      case (op)
         4'd1: begin
            p = 64'(la * lb);
            m_hi = p[63:32]; m_lo = p[31:0]; cycles = MULT_N;
         end
         4'd2: begin
            p = {32'd0, a} * {32'd0, b};
            m_hi = p[63:32]; m_lo = p[31:0]; cycles = MULT_N;
         end
         4'd3: begin
            if (b != 32'd0) begin
               lq = la / lb;
               lr = la % lb;
               m_lo = lq[31:0]; m_hi = lr[31:0];
            end
            cycles = DIV_N;
         end
         4'd4: begin
            if (b != 32'd0) begin
               m_lo = a / b; m_hi = a % b;
            end
            cycles = DIV_N;
         end
         4'd7: m_hi = a;
         4'd8: m_lo = a;
         default: ;
      endcase
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      src_a = 32'd0;
      src_b = 32'd0;
      step();
      step();
      reset = 1'b0;
      mdu_op = 4'd5;
      #1;
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      n_tests++;
      if (mdu_out !== 32'd0) begin n_fail++; $display("FAIL reset_mfhi got=%h exp=0", mdu_out); end
      mdu_op = 4'd6;
      #1;
      n_tests++;
      if (mdu_out !== 32'd0) begin n_fail++; $display("FAIL reset_mflo got=%h exp=0", mdu_out); end
      n_tests++;
      if (mdu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%0b exp=0", mdu_stall); end
      mdu_op = 4'd0;
   endtask

   task automatic test_mult();
      logic [3:0]  op;
      logic [31:0] exp_hi;
      for (int v = 0; v < 2; v++) begin
         op     = (v == 0) ? 4'd1 : 4'd2;
         exp_hi = (v == 0) ? 32'hFFFF_FFFF : 32'h0000_0001;
         drive_op(op, 32'hFFFF_FFFF, 32'd2);
         #1;
         n_tests++;
         if (mdu_stall !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mult_issue op=%0d stall=%0b busy=%0b exp stall=1 busy=0", op, mdu_stall, busy);
         end
         step();
         idle_inputs();
         for (int k = 1; k <= MULT_N; k++) begin
            n_tests++;
            if (busy !== 1'b1 || mdu_stall !== 1'b1) begin
               n_fail++; $display("FAIL mult_busy op=%0d cyc=%0d busy=%0b stall=%0b exp 1/1", op, k, busy, mdu_stall);
            end
            step();
         end
         n_tests++;
         if (busy !== 1'b0 || hi_q !== exp_hi || lo_q !== 32'hFFFF_FFFE) begin
            n_fail++; $display("FAIL mult_result op=%0d busy=%0b hi=%h lo=%h exp busy=0 hi=%h lo=fffffffe",
                               op, busy, hi_q, lo_q, exp_hi);
         end
      end
   endtask

   task automatic test_div();
      int          cnt;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic [31:0] exp_lo;
      logic [31:0] exp_hi;
      for (int v = 0; v < 3; v++) begin
         case (v)
            0: begin op = 4'd3; a = 32'hFFFF_FFF9; b = 32'd2;         exp_lo = 32'hFFFF_FFFD; exp_hi = 32'hFFFF_FFFF; end
            1: begin op = 4'd4; a = 32'd7;         b = 32'd2;         exp_lo = 32'd3;         exp_hi = 32'd1; end
            default: begin op = 4'd3; a = 32'h8000_0000; b = 32'hFFFF_FFFF; exp_lo = 32'h8000_0000; exp_hi = 32'd0; end
         endcase
         drive_op(op, a, b);
         step();
         idle_inputs();
         cnt = 0;
         while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            step();
         end
         n_tests++;
         if (cnt !== DIV_N) begin n_fail++; $display("FAIL div_busy_len case=%0d got=%0d exp=%0d", v, cnt, DIV_N); end
         n_tests++;
         if (lo_q !== exp_lo || hi_q !== exp_hi) begin
            n_fail++; $display("FAIL div_result case=%0d hi=%h lo=%h exp hi=%h lo=%h", v, hi_q, lo_q, exp_hi, exp_lo);
         end
      end
   endtask

   task automatic test_mt_and_divzero();
      int busy_seen;
      int cnt;
      busy_seen = 0;
      drive_op(4'd7, 32'h1234_5678, 32'd0);
      step();
      if (busy === 1'b1) busy_seen++;
      drive_op(4'd8, 32'h9ABC_DEF0, 32'd0);
      step();
      if (busy === 1'b1) busy_seen++;
      idle_inputs();
      mdu_op = 4'd5;
      #1;
      n_tests++;
      if (mdu_out !== 32'h1234_5678) begin n_fail++; $display("FAIL mthi_read got=%h exp=12345678", mdu_out); end
      mdu_op = 4'd6;
      #1;
      n_tests++;
      if (mdu_out !== 32'h9ABC_DEF0) begin n_fail++; $display("FAIL mtlo_read got=%h exp=9abcdef0", mdu_out); end
      n_tests++;
      if (busy_seen !== 0) begin n_fail++; $display("FAIL mt_busy got=%0d busy cycles exp=0", busy_seen); end
      // Divide by zero: full busy duration, HI/LO untouched.
      drive_op(4'd3, 32'd100, 32'd0);
      step();
      idle_inputs();
      cnt = 0;
      while (busy === 1'b1 && cnt < 40) begin
         cnt++;
         step();
      end
      n_tests++;
      if (cnt !== DIV_N) begin n_fail++; $display("FAIL divzero_busy_len got=%0d exp=%0d", cnt, DIV_N); end
      n_tests++;
      if (hi_q !== 32'h1234_5678 || lo_q !== 32'h9ABC_DEF0) begin
         n_fail++; $display("FAIL divzero_keep hi=%h lo=%h exp hi=12345678 lo=9abcdef0", hi_q, lo_q);
      end
   endtask

   task automatic test_busy_ignore();
      int cnt;
      drive_op(4'd2, 32'h0001_0000, 32'h0003_0000);   // product 0x3_0000_0000
      step();
      idle_inputs();
      step();                                         // now at T+2
      drive_op(4'd7, 32'hDEAD_BEEF, 32'd0);
      step();
      idle_inputs();
      cnt = 0;
      while (busy === 1'b1 && cnt < 40) begin
         cnt++;
         step();
      end
      n_tests++;
      if (cnt !== MULT_N - 2) begin n_fail++; $display("FAIL ignore_busy_len got=%0d exp=%0d", cnt, MULT_N - 2); end
      n_tests++;
      if (hi_q !== 32'd3 || lo_q !== 32'd0) begin
         n_fail++; $display("FAIL ignore_result hi=%h lo=%h exp hi=00000003 lo=00000000", hi_q, lo_q);
      end
   endtask

   task automatic test_reset_abort();
      drive_op(4'd4, 32'd1000, 32'd7);
      step();                                         // T+1
      idle_inputs();
      step();
      step();
      step();                                         // T+4
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_tests++;
      if (busy !== 1'b0 || hi_q !== 32'd0 || lo_q !== 32'd0) begin
         n_fail++; $display("FAIL abort_state busy=%0b hi=%h lo=%h exp 0/0/0", busy, hi_q, lo_q);
      end
      for (int k = 0; k < DIV_N + 2; k++) step();
      n_tests++;
      if (busy !== 1'b0 || hi_q !== 32'd0 || lo_q !== 32'd0) begin
         n_fail++; $display("FAIL abort_late_write busy=%0b hi=%h lo=%h exp 0/0/0", busy, hi_q, lo_q);
      end
   endtask

   task automatic test_random();
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          exp_cyc;
      int          cnt;
      int          sel;
      reset = 1'b1;
      step();
      reset = 1'b0;
      m_hi = 32'd0;
      m_lo = 32'd0;
      for (int i = 0; i < 60; i++) begin
         sel = $urandom_range(0, 11);
         op  = (sel <= 8) ? 4'(sel) : 4'($urandom_range(9, 15));
         a   = $urandom;
         b   = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 9));
            default: ;
         endcase
         model_exec(op, a, b, exp_cyc);
         drive_op(op, a, b);
         step();
         idle_inputs();
         cnt = 0;
         while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            step();
         end
         n_tests++;
         if (cnt !== exp_cyc) begin
            n_fail++; $display("FAIL rand_busy i=%0d op=%0d got=%0d exp=%0d", i, op, cnt, exp_cyc);
         end
         n_tests++;
         if (hi_q !== m_hi || lo_q !== m_lo) begin
            n_fail++; $display("FAIL rand_hilo i=%0d op=%0d a=%h b=%h hi=%h lo=%h exp hi=%h lo=%h",
                               i, op, a, b, hi_q, lo_q, m_hi, m_lo);
         end
         mdu_op = ($urandom_range(0, 1) == 0) ? 4'd5 : 4'd6;
         #1;
         n_tests++;
         if (mdu_out !== ((mdu_op == 4'd5) ? m_hi : m_lo)) begin
            n_fail++; $display("FAIL rand_read i=%0d sel=%0d got=%h exp=%h", i, mdu_op, mdu_out,
                               (mdu_op == 4'd5) ? m_hi : m_lo);
         end
         mdu_op = 4'd0;
         step();
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b1;
      start   = 1'b0;
      mdu_op  = 4'd0;
      src_a   = 32'd0;
      src_b   = 32'd0;
      m_hi    = 32'd0;
      m_lo    = 32'd0;
      #1;
      test_reset();
      test_mult();
      test_div();
      test_mt_and_divzero();
      test_busy_ignore();
      test_reset_abort();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
